// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and constant helpers for the framebuffer scheduler
package vga_fb_pkg;
    localparam int def_color_depth = 8;

    typedef struct packed {
        logic [def_color_depth-1:0] r;
        logic [def_color_depth-1:0] g;
        logic [def_color_depth-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        DONE = 2'd0,
        IDLE = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic int clog2(input longint n);
        int r;
        r = 0;
        while ((longint'(1) << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: synchronous pixel FIFO with occupancy count and flush
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO, overrides push/pop
//   push, din  : write an entry (never issued while full)
//   pop        : consume the head entry; ignored while empty
//   dout       : head entry, 0 while empty
//   count      : number of stored entries
module vga_pixel_fifo
    import vga_fb_pkg::*;
#(
    parameter int depth = 16,
    parameter int width = 24,
    localparam int cw = clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [cw-1:0]    count
);
    localparam int aw = clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wp;
    logic [aw-1:0]    rp;
    logic             do_pop;

    assign do_pop = pop && count != '0;
    assign dout   = count != '0 ? mem[rp] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + aw'(1) : wp;
            rp    <= do_pop ? rp + aw'(1) : rp;
            count <= count + cw'(push) - cw'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= din;
    end
endmodule

// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: arbitrates a single-port framebuffer between scan-out prefetch and a pixel writer
//   frame_start            : restart prefetch at address 0, flush FIFO, clear underflow
//   pix_rd / pix_valid     : display pops the head pixel / FIFO non-empty
//   pix_r, pix_g, pix_b    : head pixel, 0 while empty
//   underflow              : sticky, pix_rd seen while empty
//   wr_req/addr/data, ack  : writer handshake; ack pulses with the issued write
//   mem_en/we/addr/wdata   : registered memory command, one per cycle
//   mem_rdata              : read data, valid mem_lat cycles after a read issue
module vga_fb_scheduler
    import vga_fb_pkg::*;
#(
    parameter int vga_width   = 1024,
    parameter int vga_height  = 768,
    parameter int color_depth = 8,
    parameter int fifo_depth  = 16,
    parameter int low_wm      = 8,
    parameter int mem_lat     = 2,
    localparam int addr_w = clog2(vga_width * vga_height),
    localparam int pw     = 3 * color_depth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   pix_rd,
    output logic                   pix_valid,
    output logic [color_depth-1:0] pix_r,
    output logic [color_depth-1:0] pix_g,
    output logic [color_depth-1:0] pix_b,
    output logic                   underflow,
    input  logic                   wr_req,
    input  logic [addr_w-1:0]      wr_addr,
    input  logic [pw-1:0]          wr_data,
    output logic                   wr_ack,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [addr_w-1:0]      mem_addr,
    output logic [pw-1:0]          mem_wdata,
    input  logic [pw-1:0]          mem_rdata
);
    localparam int cw = clog2(fifo_depth + 1);
    localparam int iw = clog2(mem_lat + 1);
    localparam int ow = clog2(fifo_depth + mem_lat + 1);
    localparam logic [addr_w-1:0] last_addr = addr_w'(vga_width * vga_height - 1);

    state_t            state;
    state_t            state_n;
    logic [addr_w-1:0] rd_addr;
    logic [mem_lat-1:0] pend;
    logic [mem_lat:0]  pend_n;
    logic [iw-1:0]     inflight;
    logic [iw-1:0]     discard;
    logic [cw-1:0]     fifo_count;
    logic [ow-1:0]     occ;
    logic [pw-1:0]     head;
    logic              ret;
    logic              keep;
    logic              rd_go;
    logic              wr_go;

    // pend is a one-hot-per-cycle history of read issues; the oldest bit marks the return edge
    assign pend_n = {pend, rd_go};
    assign ret    = pend[mem_lat-1];
    assign keep   = ret && discard == '0;
    assign occ    = ow'(fifo_count) + ow'(inflight);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < mem_lat; i++) inflight = inflight + iw'(pend[i]);
    end

    // wr_ack masks the request for one cycle: the writer still holds wr_req while it sees the ack
    always_comb begin
        state_n = state;
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        if (frame_start) begin
            state_n = FILL;
        end else begin
            rd_go = state == FILL && occ < ow'(fifo_depth);
            wr_go = wr_req && !wr_ack && !rd_go;
            if (state == FILL) state_n = !rd_go ? IDLE : rd_addr == last_addr ? DONE : FILL;
            if (state == IDLE && occ <= ow'(low_wm)) state_n = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DONE;
            rd_addr   <= '0;
            pend      <= '0;
            discard   <= '0;
            underflow <= 1'b0;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            pend      <= pend_n[mem_lat-1:0];
            wr_ack    <= wr_go;
            mem_en    <= rd_go || wr_go;
            mem_we    <= wr_go;
            mem_addr  <= wr_go ? wr_addr : rd_go ? rd_addr : '0;
            mem_wdata <= wr_go ? wr_data : '0;
            rd_addr   <= frame_start ? '0 : rd_go ? rd_addr + addr_w'(1) : rd_addr;
            // a return landing on the frame_start edge is dropped by the flush, so it is not discarded again
            discard   <= frame_start ? inflight - iw'(ret) : (ret && discard != '0) ? discard - iw'(1) : discard;
            underflow <= frame_start ? 1'b0 : underflow || (pix_rd && fifo_count == '0);
        end
    end

    vga_pixel_fifo #(
        .depth(fifo_depth),
        .width(pw)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(frame_start),
        .push (keep),
        .pop  (pix_rd),
        .din  (mem_rdata),
        .dout (head),
        .count(fifo_count)
    );

    assign pix_valid = fifo_count != '0;
    assign {pix_r, pix_g, pix_b} = head;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed self-checking bench with pixel and write scoreboards
module tb_vga_fb_scheduler;
    localparam int vw   = 1024;
    localparam int vh   = 4;
    localparam int cd   = 8;
    localparam int aw   = 12;
    localparam int pw   = 3 * cd;
    localparam int npix = vw * vh;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_rd = 1'b0;
    logic          pix_valid;
    logic [cd-1:0] pix_r, pix_g, pix_b;
    logic          underflow;
    logic          wr_req = 1'b0;
    logic [aw-1:0] wr_addr = '0;
    logic [pw-1:0] wr_data = '0;
    logic          wr_ack;
    logic          mem_en, mem_we;
    logic [aw-1:0] mem_addr;
    logic [pw-1:0] mem_wdata;
    logic [pw-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [pw-1:0]    pix_q[$];
    logic [aw+pw-1:0] wr_q[$];

    always #5 clk = ~clk;

    vga_fb_scheduler #(
        .vga_width(vw), .vga_height(vh), .color_depth(cd),
        .fifo_depth(16), .low_wm(8), .mem_lat(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .underflow(underflow), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [pw-1:0] pat(input int a);
        return pw'(a * 257) ^ 24'hC3A500;
    endfunction

    // two-cycle RAM: address sampled one edge after issue, data captured by the DUT on the next edge
    always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? pat(int'(mem_addr)) : 24'h0DEAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_q();
        pix_q.delete();
        for (int i = 0; i < npix; i++) pix_q.push_back(pat(i));
    endtask

    always @(negedge clk) begin
        if (rst_n && pix_rd && pix_valid) begin
            if (pix_q.size() == 0) chk("pix_q_nonempty", 64'(pix_q.size()), 1);
            else chk("pix_data", {pix_r, pix_g, pix_b}, pix_q.pop_front());
        end
        if (rst_n && mem_en && mem_we) begin
            if (wr_q.size() == 0) chk("wr_q_nonempty", 64'(wr_q.size()), 1);
            else chk("wr_bus", {mem_addr, mem_wdata}, wr_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and no prefetch before the first frame_start
        repeat (3) tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_wr_ack", wr_ack, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_no_prefetch", mem_en, 0);
        end

        // cold fill
        frame_start = 1'b1;
        restart_q();
        tick();
        frame_start = 1'b0;
        chk("fs_no_op", mem_en, 0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k <= 16) begin
                chk("fill_en", mem_en, 1);
                chk("fill_we", mem_we, 0);
                chk("fill_addr", mem_addr, 64'(k - 1));
            end else chk("fill_stop", mem_en, 0);
            if (k == 2) chk("pv_early", pix_valid, 0);
            if (k == 3) begin
                chk("pv_first", pix_valid, 1);
                chk("pix_first", {pix_r, pix_g, pix_b}, pat(0));
            end
        end

        // write while IDLE goes out on the next cycle
        wr_req = 1'b1;
        wr_addr = 12'h345;
        wr_data = 24'hABCDEF;
        wr_q.push_back({12'h345, 24'hABCDEF});
        tick();
        chk("idle_wr_ack", wr_ack, 1);
        chk("idle_wr_we", mem_we, 1);
        chk("idle_wr_addr", mem_addr, 12'h345);
        chk("idle_wr_data", mem_wdata, 24'hABCDEF);
        wr_req = 1'b0;
        tick();
        chk("idle_wr_ack_pulse", wr_ack, 0);

        // write raised with frame_start stalls until FILL issues no read
        frame_start = 1'b1;
        restart_q();
        wr_req = 1'b1;
        wr_addr = 12'h0AB;
        wr_data = 24'h00FF00;
        wr_q.push_back({12'h0AB, 24'h00FF00});
        tick();
        frame_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("fill_wr_stall", wr_ack, 0);
            chk("fill_rd_addr", mem_addr, 64'(k - 1));
        end
        tick();
        chk("fill_wr_ack", wr_ack, 1);
        chk("fill_wr_we", mem_we, 1);
        wr_req = 1'b0;

        // steady drain: refill after the low watermark, no bubbles over a line
        pix_rd = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("drain_no_refill", mem_en, 0);
        end
        tick();
        chk("refill_en", mem_en, 1);
        chk("refill_we", mem_we, 0);
        chk("refill_addr", mem_addr, 16);
        for (int k = 0; k < vw; k++) begin
            tick();
            chk("drain_valid", pix_valid, 1);
        end
        chk("drain_underflow", underflow, 0);

        // end of frame
        for (int k = 0; k < 6000 && pix_valid; k++) tick();
        chk("frame_drained", pix_valid, 0);
        chk("frame_all_pixels", 64'(pix_q.size()), 0);
        tick();
        pix_rd = 1'b0;
        chk("underflow_set", underflow, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("done_no_read", mem_en, 0);
        end
        wr_req = 1'b1;
        wr_addr = 12'h7A5;
        wr_data = 24'h123456;
        wr_q.push_back({12'h7A5, 24'h123456});
        tick();
        chk("done_wr_ack", wr_ack, 1);
        chk("done_wr_addr", mem_addr, 12'h7A5);
        wr_req = 1'b0;
        tick();
        chk("underflow_sticky", underflow, 1);

        // frame_start with reads in flight: their returns are discarded
        frame_start = 1'b1;
        restart_q();
        tick();
        frame_start = 1'b0;
        chk("fs2_underflow_clr", underflow, 0);
        chk("fs2_pv", pix_valid, 0);
        tick();
        chk("fs2_addr0", mem_addr, 0);
        tick();
        chk("fs2_addr1", mem_addr, 1);
        frame_start = 1'b1;
        restart_q();
        tick();
        frame_start = 1'b0;
        chk("fs3_no_op", mem_en, 0);
        chk("fs3_pv", pix_valid, 0);
        tick();
        chk("fs3_addr0", mem_addr, 0);
        chk("discard_a", pix_valid, 0);
        tick();
        chk("discard_b", pix_valid, 0);
        tick();
        chk("fs3_pv_first", pix_valid, 1);
        chk("fs3_pix_first", {pix_r, pix_g, pix_b}, pat(0));
        pix_rd = 1'b1;
        repeat (30) tick();

        // asynchronous reset mid-traffic; late RAM returns are ignored
        #2;
        rst_n = 1'b0;
        pix_rd = 1'b0;
        #1;
        chk("arst_mem_en", mem_en, 0);
        chk("arst_pix_valid", pix_valid, 0);
        chk("arst_pix", {pix_r, pix_g, pix_b}, 0);
        chk("arst_mem_addr", mem_addr, 0);
        #1;
        rst_n = 1'b1;
        pix_q.delete();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_en", mem_en, 0);
            chk("post_rst_pv", pix_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
